// File: rtl/decode_stage.sv
// decode_stage: IF/ID latch with one-hot rs/rt decode and destination-select pipeline to write-back
module decode_stage #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    ibus,
    input  logic             ivalid,
    input  logic             stall,
    input  logic             flush,
    output logic [NREGS-1:0] Aselect,
    output logic [NREGS-1:0] Bselect,
    output logic [DW-1:0]    Imm,
    output logic             Imm_sel,
    output logic [NREGS-1:0] dsel_ex,
    output logic [NREGS-1:0] dsel_mem,
    output logic [NREGS-1:0] Dselect
);
    logic [DW-1:0]    r_ir;
    logic             r_v;
    logic [NREGS-1:0] r_dex;
    logic [NREGS-1:0] r_dmem;
    logic [NREGS-1:0] r_dwb;
    logic             r_vex;
    logic             r_vmem;
    logic             r_vwb;
    logic [4:0]       w_dst;
    logic [NREGS-1:0] w_dsel;
    always_comb begin
        Imm_sel  = r_ir[31:26] != 6'd0;
        w_dst    = Imm_sel ? r_ir[20:16] : r_ir[15:11];
        w_dsel   = NREGS'(1) << w_dst;
        Aselect  = NREGS'(1) << r_ir[25:21];
        Bselect  = NREGS'(1) << r_ir[20:16];
        Imm      = {{(DW-16){r_ir[15]}}, r_ir[15:0]};
        dsel_ex  = r_vex ? r_dex : '0;
        dsel_mem = r_vmem ? r_dmem : '0;
        Dselect  = r_vwb ? r_dwb : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir   <= '0;
            r_v    <= 1'b0;
            r_dex  <= '0;
            r_dmem <= '0;
            r_dwb  <= '0;
            r_vex  <= 1'b0;
            r_vmem <= 1'b0;
            r_vwb  <= 1'b0;
        end else begin
            if (flush) begin
                r_ir <= '0;
                r_v  <= 1'b0;
            end else if (!stall) begin
                r_ir <= ibus;
                r_v  <= ivalid;
            end
            r_dex  <= w_dsel;
            r_vex  <= r_v && !flush && !stall;
            r_dmem <= r_dex;
            r_vmem <= r_vex;
            r_dwb  <= r_dmem;
            r_vwb  <= r_vmem;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, bubbles, flush and pipeline fill
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ibus;
    logic        ivalid;
    logic        stall;
    logic        flush;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Imm;
    logic        Imm_sel;
    logic [31:0] dsel_ex;
    logic [31:0] dsel_mem;
    logic [31:0] Dselect;
    int          n_chk = 0;
    int          n_fail = 0;

    decode_stage #(.NREGS(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .ibus(ibus), .ivalid(ivalid),
        .stall(stall), .flush(flush), .Aselect(Aselect), .Bselect(Bselect),
        .Imm(Imm), .Imm_sel(Imm_sel), .dsel_ex(dsel_ex), .dsel_mem(dsel_mem),
        .Dselect(Dselect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] ib, input logic v, input logic st, input logic fl);
        ibus = ib;
        ivalid = v;
        stall = st;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        step(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        step(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        chk("rst_A", Aselect, 32'h1);
        chk("rst_B", Bselect, 32'h1);
        chk("rst_imm", Imm, 32'h0);
        chk("rst_imm_sel", {31'd0, Imm_sel}, 32'h0);
        chk("rst_ex", dsel_ex, 32'h0);
        chk("rst_mem", dsel_mem, 32'h0);
        chk("rst_wb", Dselect, 32'h0);
        reset = 1'b0;

        step(32'h00A62000, 1'b1, 1'b0, 1'b0);
        chk("r_A", Aselect, 32'h20);
        chk("r_B", Bselect, 32'h40);
        chk("r_imm_sel", {31'd0, Imm_sel}, 32'h0);
        chk("r_imm", Imm, 32'h00002000);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_ex", dsel_ex, 32'h10);
        chk("r_A_idle", Aselect, 32'h1);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_mem", dsel_mem, 32'h10);
        chk("r_ex_drain", dsel_ex, 32'h0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_wb", Dselect, 32'h10);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_wb_once", Dselect, 32'h0);

        step(32'h2022FFFC, 1'b1, 1'b0, 1'b0);
        chk("i_A", Aselect, 32'h2);
        chk("i_B", Bselect, 32'h4);
        chk("i_imm", Imm, 32'hFFFFFFFC);
        chk("i_imm_sel", {31'd0, Imm_sel}, 32'h1);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("i_ex", dsel_ex, 32'h4);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("i_wb", Dselect, 32'h4);

        step(32'h00A62000, 1'b1, 1'b0, 1'b0);
        chk("st_wb_clear", Dselect, 32'h0);
        step(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        chk("st1_A", Aselect, 32'h20);
        chk("st1_ex", dsel_ex, 32'h0);
        step(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        chk("st2_A", Aselect, 32'h20);
        chk("st2_ex", dsel_ex, 32'h0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("st_ex", dsel_ex, 32'h10);
        chk("st_A_after", Aselect, 32'h1);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("st_mem", dsel_mem, 32'h10);
        chk("st_wb_early", Dselect, 32'h0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("st_wb", Dselect, 32'h10);

        step(32'h2022FFFC, 1'b1, 1'b0, 1'b0);
        chk("fl_cap_A", Aselect, 32'h2);
        step(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        chk("fl_A", Aselect, 32'h1);
        chk("fl_B", Bselect, 32'h1);
        chk("fl_imm_sel", {31'd0, Imm_sel}, 32'h0);
        chk("fl_ex", dsel_ex, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 1'b0, 1'b0, 1'b0);
            chk("fl_ex_drain", dsel_ex, 32'h0);
            chk("fl_wb", Dselect, 32'h0);
        end

        step(32'h00000800, 1'b1, 1'b0, 1'b0);
        step(32'h00001000, 1'b1, 1'b0, 1'b0);
        chk("fill_ex1", dsel_ex, 32'h2);
        step(32'h00001800, 1'b1, 1'b0, 1'b0);
        chk("fill_mem1", dsel_mem, 32'h2);
        step(32'h00002000, 1'b1, 1'b0, 1'b0);
        chk("fill_wb1", Dselect, 32'h2);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_wb2", Dselect, 32'h4);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_wb3", Dselect, 32'h8);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_wb4", Dselect, 32'h10);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_wb_end", Dselect, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode front end of the five-stage processor; sits directly upstream of regfile.
- Latches each fetched instruction into an IF/ID register and decodes the register fields into the one-hot Aselect/Bselect read selects the regfile consumes.
- Carries the one-hot destination select through ID/EX, EX/MEM and MEM/WB so it reaches the regfile write port (Dselect) in the write-back cycle.
- Also produces the sign-extended immediate and the in-flight destination selects the forwarding logic needs.

Parameters:
- NREGS, 32, number of architectural registers; width of every one-hot select.
- DW, 32, instruction and immediate width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ibus  input  DW  fetched instruction
- ivalid  input  1  ibus holds a real instruction this cycle
- stall  input  1  hold IF/ID and insert a bubble into ID/EX
- flush  input  1  discard the IF/ID contents (branch taken)
- Aselect  output  NREGS  one-hot rs select to regfile
- Bselect  output  NREGS  one-hot rt select to regfile
- Imm  output  DW  sign-extended imm[15:0] of the IF/ID instruction
- Imm_sel  output  1  IF/ID instruction is I-type (opcode != 0)
- dsel_ex  output  NREGS  destination select held in ID/EX (0 if bubble)
- dsel_mem  output  NREGS  destination select held in EX/MEM (0 if bubble)
- Dselect  output  NREGS  destination select held in MEM/WB, to regfile write port (0 if bubble)

Behaviour:
- Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Destination field: R-type (opcode == 0) writes rd; I-type writes rt.
- Decode:
  - Aselect = 1 << rs; Bselect = 1 << rt, both combinational from the IF/ID register.
  - Imm = {{16{imm[15]}}, imm}.
- Valid bits: IF/ID, ID/EX, EX/MEM and MEM/WB each hold a valid bit. A stage with valid = 0 drives its destination select as all zeros, so the regfile performs no write.
- Register 0 (bit 0) is a legal destination. The regfile discards that write, so no special case is needed here.
- Each rising clk edge is evaluated in priority order:
  1. reset: IF/ID instruction = 0, all valid bits = 0.
     - Outputs: Aselect = Bselect = 32'h1, Imm = 0, Imm_sel = 0, dsel_ex = dsel_mem = Dselect = 0.
  2. flush:
     - IF/ID instruction = 0, valid = 0.
     - ID/EX loads a bubble.
     - EX/MEM and MEM/WB advance normally.
     - flush overrides stall.
  3. stall:
     - IF/ID holds its contents and ibus is ignored.
     - ID/EX loads a bubble.
     - EX/MEM and MEM/WB advance normally.
  4. Otherwise:
     - IF/ID <= {ibus, ivalid}.
     - ID/EX <= decoded destination select and valid from IF/ID.
     - EX/MEM <= ID/EX.
     - MEM/WB <= EX/MEM.
- Latency: for an instruction captured at edge N:
  - Aselect/Bselect/Imm are valid from edge N.
  - dsel_ex from N+1, dsel_mem from N+2, Dselect from N+3. Dselect is held for exactly one cycle.
- Throughput: one instruction per cycle when stall = 0.
- Back-to-back stalls hold IF/ID indefinitely and keep bubbles entering ID/EX; downstream stages drain normally.
- Every select output is either all zeros or exactly one-hot. A multi-bit value is a bug.

Test Plan:
- Reset: assert reset for 2 cycles with ibus = 32'hFFFFFFFF and ivalid = 1 -> Aselect = Bselect = 32'h1, Imm = 0, dsel_ex = dsel_mem = Dselect = 0.
- R-type: ibus = 32'h00A62000 (rs = 5, rt = 6, rd = 4), ivalid = 1 for one cycle -> after edge N Aselect = 32'h00000020, Bselect = 32'h00000040, Imm_sel = 0; dsel_ex = 32'h10 at N+1, dsel_mem = 32'h10 at N+2, Dselect = 32'h10 at N+3, Dselect = 0 at N+4.
- I-type with sign extension: ibus = 32'h2022FFFC -> Aselect = 32'h2, Bselect = 32'h4, Imm = 32'hFFFFFFFC, Imm_sel = 1, Dselect = 32'h4 three edges later.
- Stall bubble: R-type above then assert stall for 2 cycles -> Aselect holds 32'h20 through the stall; dsel_ex = 0 for both stall cycles; Dselect = 32'h10 appears 5 edges after capture.
- Flush over stall: capture 32'h2022FFFC, next cycle assert stall = 1 and flush = 1 -> IF/ID cleared (Aselect = 32'h1); dsel_ex = 0 and Dselect never shows 32'h4.
- Pipeline fill: 4 consecutive R-types with rd = 1..4 (32'h00000800, 32'h00001000, 32'h00001800, 32'h00002000) -> Dselect sequence 32'h2, 32'h4, 32'h8, 32'h10 on consecutive cycles starting 3 edges after the first capture.
